// File: rtl/mod_mul_p_if.sv
// mod_mul_p_if: start/done handshake and operand/result bus of the SM2 modular multiplier.
// The master side requests a product; the slave side is mod_mul_p.
interface mod_mul_p_if;
    localparam int unsigned W = 256;

    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         start;
    logic [W-1:0] out_c;
    logic         done;
    logic         busy;

    modport master (
        output in_a,
        output in_b,
        output start,
        input  out_c,
        input  done,
        input  busy
    );

    modport slave (
        input  in_a,
        input  in_b,
        input  start,
        output out_c,
        output done,
        output busy
    );
endinterface

// File: rtl/mod_mul_p.sv
// mod_mul_p: bit-serial out_c = in_a * in_b mod p over the SM2 prime.
// MSB-first interleaved double/add with a conditional subtraction after each half-step,
// one multiplier bit per cycle (256 MUL cycles, one FIN cycle).
// Optional feature: MOD_MUL_P_IN_REDUCE_EN reduces operands >= p once at capture.
module mod_mul_p (
    input  logic      clk,
    input  logic      rstn,
    mod_mul_p_if.slave bus
);
    localparam int unsigned W  = 256;
    localparam int unsigned CW = 8;
    localparam logic [W-1:0] P   = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [W:0]   P_X = {1'b0, P};

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        MUL  = 3'b010,
        FIN  = 3'b100
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a_r, a_nx;
    logic [W-1:0]  b_r, b_nx;
    logic [W-1:0]  r, r_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic [W-1:0]  a_cap, b_cap;
    logic [W:0]    d, t, e;
    logic [W-1:0]  r_step;

`ifdef MOD_MUL_P_IN_REDUCE_EN
    // Capture path folds any 256-bit operand into [0, p): 2^256 < 2p, so one subtraction is enough.
    always_comb begin
        a_cap = (bus.in_a >= P) ? bus.in_a - P : bus.in_a;
        b_cap = (bus.in_b >= P) ? bus.in_b - P : bus.in_b;
    end
`else
    // Capture path takes operands as-is; callers guarantee they are already below p.
    always_comb begin
        a_cap = bus.in_a;
        b_cap = bus.in_b;
    end
`endif

    // One loop step: r <- (2r + b[cnt]*a) mod p, compares done at full 257-bit width.
    always_comb begin
        d      = {r, 1'b0};
        t      = (d >= P_X) ? d - P_X : d;
        e      = b_r[cnt] ? t + {1'b0, a_r} : t;
        r_step = (e >= P_X) ? W'(e - P_X) : W'(e);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            r     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            a_r   <= a_nx;
            b_r   <= b_nx;
            r     <= r_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_nx = state;
        a_nx     = a_r;
        b_nx     = b_r;
        r_nx     = r;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_nx     = a_cap;
                    b_nx     = b_cap;
                    r_nx     = '0;
                    cnt_nx   = CW'(255);
                    state_nx = MUL;
                end
            end
            MUL: begin
                r_nx   = r_step;
                cnt_nx = cnt - CW'(1);
                if (cnt == '0) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of the state register, no path from the inputs.
    always_comb begin
        bus.done  = (state == FIN);
        bus.busy  = (state != IDLE);
        bus.out_c = (state == FIN) ? r : '0;
    end
endmodule

// File: tb/tb_mod_mul_p.sv
// tb_mod_mul_p: directed checks of mod_mul_p products, latency, handshake and reset abort.
module tb_mod_mul_p;
    localparam logic [255:0] P      = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] HALF   = 256'h7FFFFFFF_7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_80000000_80000000_00000000;
    localparam logic [255:0] INV3   = 256'h55555554_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_AAAAAAAB_00000000_00000000;
    localparam logic [255:0] INVM2  = 256'h7FFFFFFF_7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_80000000_7FFFFFFF_FFFFFFFF;
    localparam logic [255:0] PM1    = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFE;
    localparam logic [255:0] PM2    = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFD;
    localparam logic [255:0] P128   = 256'h00000000_00000000_00000000_00000001_00000000_00000000_00000000_00000000;
    localparam logic [255:0] R256   = 256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001;
    localparam logic [255:0] PP5    = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000001_00000000_00000004;
    localparam logic [255:0] ALL1   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] R256M1 = 256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000000;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    mod_mul_p_if bus ();

    mod_mul_p dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits up to max negedges for done; n is the number of negedges stepped.
    task automatic wait_done(input int max, output bit got, output int n, output logic [255:0] res);
        got = 1'b0;
        n   = 0;
        res = '0;
        while (!got && n < max) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) begin
                got = 1'b1;
                res = bus.out_c;
            end
        end
    endtask

    // Pulses start with (a, b), checks busy span, done, result and the return to idle.
    task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [255:0] exp,
                          input bit chk_val, input string tag);
        int           busy_cnt;
        bit           got;
        logic [255:0] res;
        busy_cnt = 0;
        got      = 1'b0;
        res      = '0;
        @(negedge clk);
        bus.in_a  = a;
        bus.in_b  = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_a  = ~a;
        bus.in_b  = ~b;
        check({tag, " out_c zero in MUL"}, bus.out_c, 256'd0);
        for (int i = 0; i < 300 && !got; i++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                got = 1'b1;
                res = bus.out_c;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, " done seen"}, 256'(got), 256'd1);
        check({tag, " busy cycles"}, 256'(busy_cnt), 256'd257);
        if (chk_val) check({tag, " out_c"}, res, exp);
        @(negedge clk);
        check({tag, " idle after FIN"}, 256'({bus.busy, bus.done}), 256'd0);
    endtask

    function automatic logic [255:0] rand_below_p();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom();
        if (v >= P) v = v - P;
        return v;
    endfunction

    initial begin
        bit           got;
        int           n;
        logic [255:0] res;
        logic [255:0] ra, rb;
        logic [511:0] prod;

        n_tests   = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        bus.in_a  = '0;
        bus.in_b  = '0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 256'(bus.busy), 256'd0);
        check("reset done", 256'(bus.done), 256'd0);
        check("reset out_c", bus.out_c, 256'd0);
        rstn = 1'b1;
        @(negedge clk);

        run_op(256'd2, 256'd3, 256'd6, 1'b1, "2x3");
        run_op(256'd2, HALF, 256'd1, 1'b1, "2xinv2");
        run_op(256'd3, INV3, 256'd1, 1'b1, "3xinv3");
        run_op(PM2, INVM2, 256'd1, 1'b1, "pm2xinv");
        run_op(PM1, PM1, 256'd1, 1'b1, "pm1xpm1");
        run_op(256'd0, PM1, 256'd0, 1'b1, "0xpm1");
        run_op(256'd1, PM2, PM2, 1'b1, "1xpm2");
        run_op(P128, P128, R256, 1'b1, "2^128sq");

        for (int k = 0; k < 16; k++) begin
            ra   = rand_below_p();
            rb   = rand_below_p();
            prod = 512'(ra) * 512'(rb);
            run_op(ra, rb, 256'(prod % 512'(P)), 1'b1, "random");
        end

        // start held high: back-to-back results one per 258 cycles
        @(negedge clk);
        bus.in_a  = 256'd2;
        bus.in_b  = 256'd3;
        bus.start = 1'b1;
        wait_done(300, got, n, res);
        check("b2b first latency", 256'(n), 256'd257);
        check("b2b first out_c", res, 256'd6);
        bus.in_a = 256'd5;
        bus.in_b = 256'd7;
        wait_done(300, got, n, res);
        check("b2b period", 256'(n), 256'd258);
        check("b2b second out_c", res, 256'd35);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b idle", 256'(bus.busy), 256'd0);

        // restart attempt mid-MUL is ignored and operands stay as captured
        @(negedge clk);
        bus.in_a  = 256'd7;
        bus.in_b  = 256'd11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (50) @(negedge clk);
        bus.in_a  = 256'd13;
        bus.in_b  = 256'd17;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(260, got, n, res);
        check("ignore done seen", 256'(got), 256'd1);
        check("ignore out_c", res, 256'd77);
        repeat (2) @(negedge clk);
        check("ignore no requeue", 256'(bus.busy), 256'd0);

        // asynchronous reset mid-operation aborts without done
        @(negedge clk);
        bus.in_a  = 256'd2;
        bus.in_b  = 256'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        check("pre-reset busy", 256'(bus.busy), 256'd1);
        rstn = 1'b0;
        #1;
        check("abort busy", 256'(bus.busy), 256'd0);
        check("abort done", 256'(bus.done), 256'd0);
        check("abort out_c", bus.out_c, 256'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        wait_done(300, got, n, res);
        check("abort no done", 256'(got), 256'd0);
        run_op(256'd9, 256'd9, 256'd81, 1'b1, "post-reset");

`ifdef MOD_MUL_P_IN_REDUCE_EN
        run_op(PP5, 256'd2, 256'd10, 1'b1, "reduce p+5");
        run_op(ALL1, 256'd1, R256M1, 1'b1, "reduce all1");
`else
        run_op(PP5, 256'd2, 256'd10, 1'b0, "raw p+5");
        run_op(ALL1, 256'd1, R256M1, 1'b0, "raw all1");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
